xadc_depacketizer: RTL and testbench

XADC_DEPACKETIZER -- requirements
Module: xadc_depacketizer

---
 rtl/xadc_depacketizer.sv | 239 +++++++++++++++++++++++
 tb/tb_xadc_depacketizer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_depacketizer.sv
// ---------------------------------------------------------------------------
// xadc_depacketizer
//
// Purpose:
//   Decodes a COBS-framed byte stream (0x00 = frame delimiter) into XADC
//   samples. Each decoded frame carries three bytes: tag, sample[15:8],
//   sample[7:0]. The tag routes the sample to the voltage or the current
//   output stream. Frames that are malformed or carry an unknown tag are
//   rejected with a one-cycle frame_error pulse.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready        COBS-encoded input byte stream (AXIS)
//   voltage_tdata/_tvalid/_tready    decoded voltage samples (AXIS)
//   current_tdata/_tvalid/_tready    decoded current-monitor samples (AXIS)
//   frame_error                      one-cycle pulse per rejected frame
//   error_count                      saturating count of rejected frames
//
// Configuration:
//   XADC_DEPACKETIZER_ERROR_COUNT_EN  when defined, error_count counts
//                                     frame_error pulses (saturating at 8'hFF);
//                                     otherwise it is tied to 8'h00.
// ---------------------------------------------------------------------------
module xadc_depacketizer #(
  parameter int         DATA_WIDTH  = 16,
  parameter logic [7:0] VOLTAGE_TAG = 8'h01,
  parameter logic [7:0] CURRENT_TAG = 8'h02
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] voltage_tdata,
  output logic                  voltage_tvalid,
  input  logic                  voltage_tready,
  output logic [DATA_WIDTH-1:0] current_tdata,
  output logic                  current_tvalid,
  input  logic                  current_tready,
  output logic                  frame_error,
  output logic [7:0]            error_count
);

  typedef enum logic [1:0] {CODE, DATA, EMIT, DISCARD} state_e;

  state_e     state_q, state_d;
  logic [7:0] payload0_q, payload0_d;
  logic [7:0] payload1_q, payload1_d;
  logic [7:0] payload2_q, payload2_d;
  logic [1:0] payloadLen_q, payloadLen_d;
  logic [7:0] remaining_q, remaining_d;
  logic       zeroPending_q, zeroPending_d;
  logic       frameActive_q, frameActive_d;
  logic       frameError_q, frameError_d;
  logic       resetDone_q;

  logic       inFire;
  logic       outFire;
  logic       tagOk;
  logic       appendEn;
  logic [7:0] appendByte;
  logic       clearPayload;

  assign inFire = s_tvalid && s_tready;
  assign tagOk  = (payload0_q == VOLTAGE_TAG) || (payload0_q == CURRENT_TAG);

  // State and datapath registers. resetDone_q keeps s_tready low while reset
  // is held without a combinational path from reset_n to the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CODE;
      payload0_q    <= 8'h00;
      payload1_q    <= 8'h00;
      payload2_q    <= 8'h00;
      payloadLen_q  <= 2'd0;
      remaining_q   <= 8'h00;
      zeroPending_q <= 1'b0;
      frameActive_q <= 1'b0;
      frameError_q  <= 1'b0;
      resetDone_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      payload0_q    <= payload0_d;
      payload1_q    <= payload1_d;
      payload2_q    <= payload2_d;
      payloadLen_q  <= payloadLen_d;
      remaining_q   <= remaining_d;
      zeroPending_q <= zeroPending_d;
      frameActive_q <= frameActive_d;
      frameError_q  <= frameError_d;
      resetDone_q   <= 1'b1;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    payload0_d    = payload0_q;
    payload1_d    = payload1_q;
    payload2_d    = payload2_q;
    payloadLen_d  = payloadLen_q;
    remaining_d   = remaining_q;
    zeroPending_d = zeroPending_q;
    frameActive_d = frameActive_q;
    frameError_d  = 1'b0;
    appendEn      = 1'b0;
    appendByte    = 8'h00;
    clearPayload  = 1'b0;

    case (state_q)
      CODE: begin
        if (inFire) begin
          if (s_tdata == 8'h00) begin
            // A delimiter with no preceding code byte is an empty frame.
            if (frameActive_q) begin
              frameActive_d = 1'b0;
              zeroPending_d = 1'b0;
              if (payloadLen_q == 2'd3 && tagOk) begin
                state_d = EMIT;
              end else begin
                frameError_d = 1'b1;
                clearPayload = 1'b1;
              end
            end
          end else begin
            frameActive_d = 1'b1;
            // The zero implied by the previous block only materialises once
            // another code byte proves it was not the trailing one.
            if (zeroPending_q && payloadLen_q == 2'd3) begin
              frameError_d = 1'b1;
              clearPayload = 1'b1;
              state_d      = DISCARD;
            end else begin
              appendEn      = zeroPending_q;
              appendByte    = 8'h00;
              remaining_d   = s_tdata - 8'd1;
              zeroPending_d = (s_tdata != 8'hFF);
              state_d       = (s_tdata == 8'h01) ? CODE : DATA;
            end
          end
        end
      end

      DATA: begin
        if (inFire) begin
          if (s_tdata == 8'h00) begin
            // Early delimiter: it already terminates the frame, so decoding
            // restarts directly at the next code byte instead of discarding
            // the following (good) frame.
            frameError_d  = 1'b1;
            clearPayload  = 1'b1;
            frameActive_d = 1'b0;
            state_d       = CODE;
          end else if (payloadLen_q == 2'd3) begin
            frameError_d = 1'b1;
            clearPayload = 1'b1;
            state_d      = DISCARD;
          end else begin
            appendEn    = 1'b1;
            appendByte  = s_tdata;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_d = CODE;
            end
          end
        end
      end

      DISCARD: begin
        if (inFire && s_tdata == 8'h00) begin
          frameActive_d = 1'b0;
          state_d       = CODE;
        end
      end

      EMIT: begin
        if (outFire) begin
          clearPayload = 1'b1;
          state_d      = CODE;
        end
      end

      default: state_d = CODE;
    endcase

    if (appendEn) begin
      case (payloadLen_q)
        2'd0:    payload0_d = appendByte;
        2'd1:    payload1_d = appendByte;
        2'd2:    payload2_d = appendByte;
        default: ;
      endcase
      payloadLen_d = payloadLen_q + 2'd1;
    end

    if (clearPayload) begin
      payload0_d    = 8'h00;
      payload1_d    = 8'h00;
      payload2_d    = 8'h00;
      payloadLen_d  = 2'd0;
      remaining_d   = 8'h00;
      zeroPending_d = 1'b0;
    end
  end

  // Outputs. The voltage tag wins if both tags are configured equal, so the
  // two outputs can never be valid together.
  always_comb begin
    s_tready       = resetDone_q && (state_q != EMIT);
    voltage_tvalid = (state_q == EMIT) && (payload0_q == VOLTAGE_TAG);
    current_tvalid = (state_q == EMIT) && (payload0_q == CURRENT_TAG)
                     && (payload0_q != VOLTAGE_TAG);
    voltage_tdata  = voltage_tvalid ? DATA_WIDTH'({payload1_q, payload2_q})
                                    : '0;
    current_tdata  = current_tvalid ? DATA_WIDTH'({payload1_q, payload2_q})
                                    : '0;
    outFire        = (voltage_tvalid && voltage_tready)
                     || (current_tvalid && current_tready);
    frame_error    = frameError_q;
  end

`ifdef XADC_DEPACKETIZER_ERROR_COUNT_EN
  logic [7:0] errorCount_q;

  // Saturating count of rejected frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      errorCount_q <= 8'h00;
    end else if (frameError_q && errorCount_q != 8'hFF) begin
      errorCount_q <= errorCount_q + 8'd1;
    end
  end

  assign error_count = errorCount_q;
`else
  assign error_count = 8'h00;
`endif

endmodule

// File: tb/tb_xadc_depacketizer.sv
// ---------------------------------------------------------------------------
// tb_xadc_depacketizer
//
// Directed self-checking bench for xadc_depacketizer. Inputs are driven just
// after the rising edge and everything is sampled on the falling edge. A
// monitor collects every output transfer and frame_error pulse into queues
// that the scenario tasks compare against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_xadc_depacketizer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] voltage_tdata;
  logic        voltage_tvalid;
  logic        voltage_tready;
  logic [15:0] current_tdata;
  logic        current_tvalid;
  logic        current_tready;
  logic        frame_error;
  logic [7:0]  error_count;

  int          nCompared = 0;
  int          nMismatched = 0;
  int          errSeen = 0;
  int          overlapSeen = 0;
  logic [15:0] voltQ[$];
  logic [15:0] currQ[$];
  bit          orderQ[$];
  logic [7:0]  txQ[$];

  xadc_depacketizer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .voltage_tdata  (voltage_tdata),
    .voltage_tvalid (voltage_tvalid),
    .voltage_tready (voltage_tready),
    .current_tdata  (current_tdata),
    .current_tvalid (current_tvalid),
    .current_tready (current_tready),
    .frame_error    (frame_error),
    .error_count    (error_count)
  );

  always #5 clk = ~clk;

  // Monitor: a handshake seen on the falling edge completes on the next
  // rising edge, because the bench only changes inputs after rising edges.
  always @(negedge clk) begin
    if (reset_n) begin
      if (voltage_tvalid && voltage_tready) begin
        voltQ.push_back(voltage_tdata);
        orderQ.push_back(1'b0);
      end
      if (current_tvalid && current_tready) begin
        currQ.push_back(current_tdata);
        orderQ.push_back(1'b1);
      end
      if (frame_error) errSeen++;
      if (voltage_tvalid && current_tvalid) overlapSeen++;
    end
  end

  task automatic clearScoreboard();
    voltQ.delete();
    currQ.delete();
    orderQ.delete();
    errSeen = 0;
  endtask

  // Send one byte and return just after the rising edge that accepted it.
  task automatic sendByte(input logic [7:0] b);
    bit ok = 1'b0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    if (!ok) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL send_timeout: byte %h s_tready stayed 0, required 1", b);
    end
  endtask

  task automatic sendAll();
    while (txQ.size() > 0) sendByte(txQ.pop_front());
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    s_tvalid       = 1'b0;
    s_tdata        = 8'h00;
    voltage_tready = 1'b1;
    current_tready = 1'b1;
    repeat (3) @(negedge clk);
    nCompared++;
    if (s_tready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_s_tready: got %b required 0", s_tready);
    end
    nCompared++;
    if ({voltage_tvalid, current_tvalid} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL reset_tvalid: got %b required 00", {voltage_tvalid, current_tvalid});
    end
    nCompared++;
    if ({voltage_tdata, current_tdata} !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_tdata: got %h required 0", {voltage_tdata, current_tdata});
    end
    nCompared++;
    if (frame_error !== 1'b0 || error_count !== 8'h00) begin
      nMismatched++;
      $display("[TB] FAIL reset_error: got %b/%h required 0/00", frame_error, error_count);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idleCycles(2);
    clearScoreboard();
  endtask

  task automatic test_voltage();
    clearScoreboard();
    txQ = '{8'h04, 8'h01, 8'h12, 8'h34, 8'h00};
    sendAll();
    // Output valid must be up on the cycle after the delimiter was accepted.
    @(negedge clk);
    nCompared++;
    if (voltage_tvalid !== 1'b1 || voltage_tdata !== 16'h1234) begin
      nMismatched++;
      $display("[TB] FAIL voltage_latency: got v=%b d=%h required v=1 d=1234", voltage_tvalid, voltage_tdata);
    end
    idleCycles(5);
    nCompared++;
    if (voltQ.size() !== 1 || currQ.size() !== 0 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL voltage_counts: got v=%0d c=%0d e=%0d required 1/0/0", voltQ.size(), currQ.size(), errSeen);
    end else begin
      nCompared++;
      if (voltQ[0] !== 16'h1234) begin
        nMismatched++;
        $display("[TB] FAIL voltage_data: got %h required 1234", voltQ[0]);
      end
    end
  endtask

  task automatic test_embedded_zero();
    clearScoreboard();
    txQ = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h00};
    sendAll();
    idleCycles(5);
    nCompared++;
    if (currQ.size() !== 1 || voltQ.size() !== 0 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL zero_current_counts: got c=%0d v=%0d e=%0d required 1/0/0", currQ.size(), voltQ.size(), errSeen);
    end else begin
      nCompared++;
      if (currQ[0] !== 16'h0000) begin
        nMismatched++;
        $display("[TB] FAIL zero_current_data: got %h required 0000", currQ[0]);
      end
    end
    clearScoreboard();
    txQ = '{8'h03, 8'h01, 8'h12, 8'h01, 8'h00};
    sendAll();
    idleCycles(5);
    nCompared++;
    if (voltQ.size() !== 1 || currQ.size() !== 0 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL zero_voltage_counts: got v=%0d c=%0d e=%0d required 1/0/0", voltQ.size(), currQ.size(), errSeen);
    end else begin
      nCompared++;
      if (voltQ[0] !== 16'h1200) begin
        nMismatched++;
        $display("[TB] FAIL zero_voltage_data: got %h required 1200", voltQ[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clearScoreboard();
    current_tready = 1'b0;
    txQ = '{8'h04, 8'h02, 8'hAB, 8'hCD, 8'h00};
    sendAll();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nCompared++;
      if (s_tready !== 1'b0 || current_tvalid !== 1'b1 || current_tdata !== 16'hABCD) begin
        nMismatched++;
        $display("[TB] FAIL stall_cycle%0d: got rdy=%b cv=%b cd=%h required 0/1/abcd", i, s_tready, current_tvalid, current_tdata);
      end
      @(posedge clk);
      #1;
    end
    current_tready = 1'b1;
    // COBS encoding of payload 01 00 01 (voltage sample 0x0001).
    txQ = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h00};
    sendAll();
    idleCycles(5);
    nCompared++;
    if (orderQ.size() !== 2 || currQ.size() !== 1 || voltQ.size() !== 1 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_counts: got n=%0d c=%0d v=%0d e=%0d required 2/1/1/0", orderQ.size(), currQ.size(), voltQ.size(), errSeen);
    end else begin
      nCompared++;
      if (orderQ[0] !== 1'b1 || orderQ[1] !== 1'b0 || currQ[0] !== 16'hABCD || voltQ[0] !== 16'h0001) begin
        nMismatched++;
        $display("[TB] FAIL b2b_data: got order=%b%b c=%h v=%h required 10 abcd 0001", orderQ[0], orderQ[1], currQ[0], voltQ[0]);
      end
    end
  endtask

  task automatic test_errors();
    logic [7:0] expCount;
`ifdef XADC_DEPACKETIZER_ERROR_COUNT_EN
    expCount = 8'd3;
`else
    expCount = 8'd0;
`endif
    clearScoreboard();
    txQ = '{8'h04, 8'h03, 8'h11, 8'h22, 8'h00,
            8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'h00,
            8'h04, 8'h01, 8'h11, 8'h00};
    sendAll();
    idleCycles(4);
    nCompared++;
    if (errSeen !== 3 || voltQ.size() !== 0 || currQ.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL error_pulses: got e=%0d v=%0d c=%0d required 3/0/0", errSeen, voltQ.size(), currQ.size());
    end
    nCompared++;
    if (error_count !== expCount) begin
      nMismatched++;
      $display("[TB] FAIL error_count: got %0d required %0d", error_count, expCount);
    end
    clearScoreboard();
    txQ = '{8'h04, 8'h01, 8'h12, 8'h34, 8'h00};
    sendAll();
    idleCycles(5);
    nCompared++;
    if (voltQ.size() !== 1 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL error_recover_counts: got v=%0d e=%0d required 1/0", voltQ.size(), errSeen);
    end else begin
      nCompared++;
      if (voltQ[0] !== 16'h1234) begin
        nMismatched++;
        $display("[TB] FAIL error_recover_data: got %h required 1234", voltQ[0]);
      end
    end
  endtask

  task automatic test_empty_and_reset();
    clearScoreboard();
    txQ = '{8'h00, 8'h00, 8'h04, 8'h01, 8'h12, 8'h34, 8'h00};
    sendAll();
    idleCycles(5);
    nCompared++;
    if (voltQ.size() !== 1 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL empty_counts: got v=%0d e=%0d required 1/0", voltQ.size(), errSeen);
    end else begin
      nCompared++;
      if (voltQ[0] !== 16'h1234) begin
        nMismatched++;
        $display("[TB] FAIL empty_data: got %h required 1234", voltQ[0]);
      end
    end
    clearScoreboard();
    txQ = '{8'h04, 8'h01};
    sendAll();
    reset_n = 1'b0;
    idleCycles(3);
    reset_n = 1'b1;
    idleCycles(3);
    nCompared++;
    if (voltQ.size() !== 0 || currQ.size() !== 0 || voltage_tvalid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_no_output: got v=%0d c=%0d vv=%b required 0/0/0", voltQ.size(), currQ.size(), voltage_tvalid);
    end
    txQ = '{8'h04, 8'h01, 8'h56, 8'h78, 8'h00};
    sendAll();
    idleCycles(5);
    nCompared++;
    if (voltQ.size() !== 1 || errSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_counts: got v=%0d e=%0d required 1/0", voltQ.size(), errSeen);
    end else begin
      nCompared++;
      if (voltQ[0] !== 16'h5678) begin
        nMismatched++;
        $display("[TB] FAIL midreset_data: got %h required 5678", voltQ[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_voltage();
    test_embedded_zero();
    test_back_to_back();
    test_errors();
    test_empty_and_reset();
    nCompared++;
    if (overlapSeen !== 0) begin
      nMismatched++;
      $display("[TB] FAIL output_overlap: got %0d cycles required 0", overlapSeen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
